// File: rtl/pkt_frame_chk.sv
// ============================================================================
// pkt_frame_chk
// ----------------------------------------------------------------------------
// Packet-stream checker placed directly after the packet FIFO. It consumes the
// FIFO's valid/sop/eop/data stream with no backpressure. For every packet it:
//   - checks sop/eop framing,
//   - counts the packet length in words,
//   - forms the 16-bit (DATA_W) wrap-around sum of the data words,
//   - emits a one-cycle report when the packet completes.
// Saturating good-packet and error counters are provided for status readout.
//
// Optional feature (compile-time macro PKT_CONTIG_CHK_EN):
//   When defined, every word after the first in a packet must equal the
//   previous word + 1 (mod 2^DATA_W). Any break sets a per-packet flag that is
//   reported as rpt_seq_err. When undefined, no previous-word register exists
//   and rpt_seq_err is tied to 0.
//
// Parameters:
//   DATA_W  - data word width
//   LEN_W   - length counter / report width
//   MAX_LEN - longest legal packet in words; longer packets set rpt_long
//   CNT_W   - width of the statistics counters
//
// Ports:
//   clk         in   clock
//   rst_n       in   synchronous active-low reset
//   din_vld     in   word valid
//   din_sop     in   first word of packet (qualified by din_vld)
//   din_eop     in   last word of packet (qualified by din_vld)
//   din         in   data word
//   rpt_vld     out  one-cycle pulse, packet report valid
//   rpt_len     out  packet length in words (saturating)
//   rpt_sum     out  sum of packet words mod 2^DATA_W
//   rpt_long    out  packet length > MAX_LEN
//   rpt_seq_err out  contiguity break inside packet (optional feature)
//   err_noeop   out  pulse: sop seen inside an open packet
//   err_nosop   out  pulse: valid word outside a packet without sop
//   pkt_cnt     out  completed packets, saturating
//   err_cnt     out  error events, saturating
// ============================================================================
module pkt_frame_chk #(
    parameter int          DATA_W  = 16,
    parameter int          LEN_W   = 16,
    parameter int unsigned MAX_LEN = 256,
    parameter int          CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic [DATA_W-1:0] din,
    output logic              rpt_vld,
    output logic [LEN_W-1:0]  rpt_len,
    output logic [DATA_W-1:0] rpt_sum,
    output logic              rpt_long,
    output logic              rpt_seq_err,
    output logic              err_noeop,
    output logic              err_nosop,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic {
        IDLE,
        BODY
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] sum;

    // Next-state / event signals produced by the combinational decode.
    state_t            nxt_state;
    logic [LEN_W-1:0]  nxt_len;
    logic [DATA_W-1:0] nxt_sum;
    logic [LEN_W-1:0]  len_inc;
    logic [DATA_W-1:0] sum_add;
    logic              done;
    logic [LEN_W-1:0]  fin_len;
    logic [DATA_W-1:0] fin_sum;
    logic              fin_long;
    logic              fin_seq;
    logic              ev_noeop;
    logic              ev_nosop;
    logic [1:0]        err_inc;
    logic [CNT_W:0]    err_sum;
    logic [CNT_W-1:0]  nxt_err_cnt;
    logic [CNT_W-1:0]  nxt_pkt_cnt;

    // Length saturates so very long packets still report as "long" rather
    // than wrapping back to a small, legal-looking value.
    assign len_inc = (len == {LEN_W{1'b1}}) ? len : (len + LEN_ONE);
    assign sum_add = sum + din;

    // Compared at 33 bits so a MAX_LEN at or above 2^LEN_W simply never fires
    // instead of being truncated into a smaller threshold.
    assign fin_long = (33'(fin_len) > 33'(MAX_LEN));

`ifdef PKT_CONTIG_CHK_EN
    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

    logic [DATA_W-1:0] prev_word;
    logic              seq_flag;
    logic              seq_mismatch;

    assign seq_mismatch = (din != (prev_word + DATA_ONE));

    // A single-word packet (sop with eop) cannot break contiguity; otherwise
    // the final word's own check is folded in with the latched flag.
    assign fin_seq = din_sop ? 1'b0 : (seq_flag | seq_mismatch);

    // Previous-word tracker and per-packet contiguity flag. Only words that
    // belong to a packet update it; a sop restarts the chain and clears the
    // flag, so a packet counts once in err_cnt however many breaks it has.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_word <= '0;
            seq_flag  <= 1'b0;
        end else if (din_vld) begin
            if (din_sop) begin
                prev_word <= din;
                seq_flag  <= 1'b0;
            end else if (state == BODY) begin
                prev_word <= din;
                seq_flag  <= din_eop ? 1'b0 : (seq_flag | seq_mismatch);
            end
        end
    end
`else
    assign fin_seq = 1'b0;
`endif

    // Framing decode. A sop always starts a new packet, whether or not one is
    // already open; an open packet interrupted this way is dropped silently
    // apart from the err_noeop pulse.
    always_comb begin
        nxt_state = state;
        nxt_len   = len;
        nxt_sum   = sum;
        done      = 1'b0;
        fin_len   = len_inc;
        fin_sum   = sum_add;
        ev_noeop  = 1'b0;
        ev_nosop  = 1'b0;
        if (din_vld) begin
            if (din_sop) begin
                ev_noeop = (state == BODY);
                if (din_eop) begin
                    done      = 1'b1;
                    fin_len   = LEN_ONE;
                    fin_sum   = din;
                    nxt_state = IDLE;
                    nxt_len   = '0;
                    nxt_sum   = '0;
                end else begin
                    nxt_state = BODY;
                    nxt_len   = LEN_ONE;
                    nxt_sum   = din;
                end
            end else if (state == IDLE) begin
                ev_nosop = 1'b1;
            end else if (din_eop) begin
                done      = 1'b1;
                nxt_state = IDLE;
                nxt_len   = '0;
                nxt_sum   = '0;
            end else begin
                nxt_len = len_inc;
                nxt_sum = sum_add;
            end
        end
    end

    // Several error events can land in the same cycle (an interrupted packet
    // plus a flagged single-word packet), so err_cnt adds a count, not a bit.
    assign err_inc = 2'(ev_noeop) + 2'(ev_nosop)
                   + 2'(done & fin_long) + 2'(done & fin_seq);

    assign err_sum     = {1'b0, err_cnt} + (CNT_W+1)'(err_inc);
    assign nxt_err_cnt = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];

    assign nxt_pkt_cnt = (done && (pkt_cnt != {CNT_W{1'b1}})) ?
                         (pkt_cnt + CNT_W'(1)) : pkt_cnt;

    // Framing FSM with registered report, pulses and counters. Report fields
    // only load on completion so they hold until the next packet finishes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            len         <= '0;
            sum         <= '0;
            rpt_vld     <= 1'b0;
            rpt_len     <= '0;
            rpt_sum     <= '0;
            rpt_long    <= 1'b0;
            rpt_seq_err <= 1'b0;
            err_noeop   <= 1'b0;
            err_nosop   <= 1'b0;
            pkt_cnt     <= '0;
            err_cnt     <= '0;
        end else begin
            state     <= nxt_state;
            len       <= nxt_len;
            sum       <= nxt_sum;
            rpt_vld   <= done;
            err_noeop <= ev_noeop;
            err_nosop <= ev_nosop;
            pkt_cnt   <= nxt_pkt_cnt;
            err_cnt   <= nxt_err_cnt;
            if (done) begin
                rpt_len     <= fin_len;
                rpt_sum     <= fin_sum;
                rpt_long    <= fin_long;
                rpt_seq_err <= fin_seq;
            end
        end
    end

endmodule

// File: tb/tb_pkt_frame_chk.sv
// ============================================================================
// tb_pkt_frame_chk
// ----------------------------------------------------------------------------
// Self-checking bench for pkt_frame_chk. A packet-level reference model
// (queue of words per open packet) predicts every output each cycle; directed
// scenarios with known constants are followed by randomized traffic.
// ============================================================================
module tb_pkt_frame_chk;

    localparam int DATA_W  = 16;
    localparam int LEN_W   = 16;
    localparam int MAX_LEN = 256;
    localparam int CNT_W   = 32;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
    localparam longint LEN_MAX = (64'd1 << LEN_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              din_vld = 1'b0;
    logic              din_sop = 1'b0;
    logic              din_eop = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              rpt_vld;
    logic [LEN_W-1:0]  rpt_len;
    logic [DATA_W-1:0] rpt_sum;
    logic              rpt_long;
    logic              rpt_seq_err;
    logic              err_noeop;
    logic              err_nosop;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  err_cnt;

    always #5 clk = ~clk;

    pkt_frame_chk #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_vld    (din_vld),
        .din_sop    (din_sop),
        .din_eop    (din_eop),
        .din        (din),
        .rpt_vld    (rpt_vld),
        .rpt_len    (rpt_len),
        .rpt_sum    (rpt_sum),
        .rpt_long   (rpt_long),
        .rpt_seq_err(rpt_seq_err),
        .err_noeop  (err_noeop),
        .err_nosop  (err_nosop),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: words of the currently open packet plus the
    // expected registered outputs.
    bit                in_pkt;
    logic [DATA_W-1:0] words[$];
    bit                exp_vld;
    logic [LEN_W-1:0]  exp_len;
    logic [DATA_W-1:0] exp_sum;
    bit                exp_long;
    bit                exp_seq;
    bit                exp_noeop;
    bit                exp_nosop;
    longint            exp_pkt;
    longint            exp_err;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        in_pkt    = 1'b0;
        words.delete();
        exp_vld   = 1'b0;
        exp_len   = '0;
        exp_sum   = '0;
        exp_long  = 1'b0;
        exp_seq   = 1'b0;
        exp_noeop = 1'b0;
        exp_nosop = 1'b0;
        exp_pkt   = 0;
        exp_err   = 0;
    endfunction

    // Summarise the finished packet held in the queue.
    function automatic void modelReport();
        longint n;
        longint s;
        bit     brk;
        n   = words.size();
        s   = 0;
        brk = 1'b0;
        foreach (words[i]) begin
            s = s + words[i];
            if (i > 0 && words[i] != DATA_W'(words[i-1] + 1))
                brk = 1'b1;
        end
        if (n > LEN_MAX) n = LEN_MAX;
        exp_vld  = 1'b1;
        exp_len  = LEN_W'(n);
        exp_sum  = DATA_W'(s);
        exp_long = (n > MAX_LEN);
`ifdef PKT_CONTIG_CHK_EN
        exp_seq  = brk;
`else
        exp_seq  = 1'b0;
`endif
        exp_pkt  = (exp_pkt + 1 > CNT_MAX) ? CNT_MAX : exp_pkt + 1;
        words.delete();
    endfunction

    function automatic void modelStep(input bit vld, input bit sop, input bit eop,
                                      input logic [DATA_W-1:0] d);
        longint ev;
        exp_vld   = 1'b0;
        exp_noeop = 1'b0;
        exp_nosop = 1'b0;
        if (vld) begin
            if (sop) begin
                if (in_pkt) exp_noeop = 1'b1;
                words.delete();
                words.push_back(d);
                in_pkt = !eop;
                if (eop) modelReport();
            end else if (!in_pkt) begin
                exp_nosop = 1'b1;
            end else begin
                words.push_back(d);
                if (eop) begin
                    in_pkt = 1'b0;
                    modelReport();
                end
            end
        end
        ev = longint'(exp_noeop) + longint'(exp_nosop)
           + longint'(exp_vld && exp_long) + longint'(exp_vld && exp_seq);
        exp_err = (exp_err + ev > CNT_MAX) ? CNT_MAX : exp_err + ev;
    endfunction

    task automatic compareAll();
        checkOutput("rpt_vld",     64'(rpt_vld),     64'(exp_vld));
        checkOutput("rpt_len",     64'(rpt_len),     64'(exp_len));
        checkOutput("rpt_sum",     64'(rpt_sum),     64'(exp_sum));
        checkOutput("rpt_long",    64'(rpt_long),    64'(exp_long));
        checkOutput("rpt_seq_err", 64'(rpt_seq_err), 64'(exp_seq));
        checkOutput("err_noeop",   64'(err_noeop),   64'(exp_noeop));
        checkOutput("err_nosop",   64'(err_nosop),   64'(exp_nosop));
        checkOutput("pkt_cnt",     64'(pkt_cnt),     64'(exp_pkt));
        checkOutput("err_cnt",     64'(err_cnt),     64'(exp_err));
    endtask

    // One clock of stimulus: drive on the falling edge, step the model on the
    // rising edge, compare shortly after.
    task automatic applyStimulus(input bit vld, input bit sop, input bit eop,
                                 input logic [DATA_W-1:0] d);
        @(negedge clk);
        din_vld = vld;
        din_sop = sop;
        din_eop = eop;
        din     = d;
        @(posedge clk);
        modelStep(vld, sop, eop, d);
        #1;
        compareAll();
    endtask

    // Idle cycle with garbage on the qualified lines.
    task automatic idleCycle();
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), DATA_W'($urandom));
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n   = 1'b0;
        din_vld = 1'b0;
        @(posedge clk);
        modelReset();
        #1;
        compareAll();
        rst_n = 1'b1;
    endtask

    task automatic sendWords(input int n, input logic [DATA_W-1:0] start,
                             input bit contig, input bit with_sop,
                             input bit with_eop, input int max_gap);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) idleCycle();
            d = contig ? DATA_W'(start + DATA_W'(i)) : DATA_W'($urandom);
            applyStimulus(1'b1, with_sop && (i == 0), with_eop && (i == n - 1), d);
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind;
        modelReset();
        din_vld = 1'b0;

        // Reset state.
        resetDut();
        resetDut();

        // 200-word packet 0..199.
        sendWords(200, 16'd0, 1'b1, 1'b1, 1'b1, 0);
        checkOutput("tp1_vld",  64'(rpt_vld),  64'd1);
        checkOutput("tp1_len",  64'(rpt_len),  64'd200);
        checkOutput("tp1_sum",  64'(rpt_sum),  64'h4DBC);
        checkOutput("tp1_long", 64'(rpt_long), 64'd0);
        checkOutput("tp1_pkt",  64'(pkt_cnt),  64'd1);
        checkOutput("tp1_err",  64'(err_cnt),  64'd0);
        idleCycle();
        checkOutput("tp1_pulse", 64'(rpt_vld), 64'd0);

        // 30 idle, 150 words 200..349, then single-word packet.
        repeat (30) idleCycle();
        sendWords(150, 16'd200, 1'b1, 1'b1, 1'b1, 0);
        checkOutput("tp2_len", 64'(rpt_len), 64'd150);
        checkOutput("tp2_sum", 64'(rpt_sum), 64'hA0D7);
        checkOutput("tp2_pkt", 64'(pkt_cnt), 64'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'd5);
        checkOutput("tp2_single_len", 64'(rpt_len), 64'd1);
        checkOutput("tp2_single_sum", 64'(rpt_sum), 64'd5);
        checkOutput("tp2_single_vld", 64'(rpt_vld), 64'd1);

        // 300-word packet exceeds MAX_LEN.
        sendWords(300, 16'd1000, 1'b1, 1'b1, 1'b1, 0);
        checkOutput("tp3_len",  64'(rpt_len),  64'd300);
        checkOutput("tp3_long", 64'(rpt_long), 64'd1);
        checkOutput("tp3_err",  64'(err_cnt),  64'd1);
        checkOutput("tp3_pkt",  64'(pkt_cnt),  64'd4);

        // Packet interrupted by a new sop, then a stray word in IDLE.
        resetDut();
        sendWords(10, 16'd50, 1'b1, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd100);
        checkOutput("tp4_noeop", 64'(err_noeop), 64'd1);
        sendWords(3, 16'd101, 1'b1, 1'b0, 1'b1, 0);
        checkOutput("tp4_len", 64'(rpt_len), 64'd4);
        checkOutput("tp4_pkt", 64'(pkt_cnt), 64'd1);
        checkOutput("tp4_err", 64'(err_cnt), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd7);
        checkOutput("tp4_nosop",     64'(err_nosop), 64'd1);
        checkOutput("tp4_nosop_err", 64'(err_cnt),   64'd2);
        checkOutput("tp4_nosop_vld", 64'(rpt_vld),   64'd0);

        // Reset in the middle of a 50-word packet.
        sendWords(20, 16'd0, 1'b1, 1'b1, 1'b0, 0);
        resetDut();
        sendWords(30, 16'd20, 1'b1, 1'b0, 1'b1, 0);
        checkOutput("tp5_err", 64'(err_cnt), 64'd30);
        checkOutput("tp5_pkt", 64'(pkt_cnt), 64'd0);
        checkOutput("tp5_len", 64'(rpt_len), 64'd0);

        // Contiguity packets.
        resetDut();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd7);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd8);
`ifdef PKT_CONTIG_CHK_EN
        checkOutput("tp6_seq", 64'(rpt_seq_err), 64'd1);
        checkOutput("tp6_err", 64'(err_cnt),     64'd1);
`else
        checkOutput("tp6_seq", 64'(rpt_seq_err), 64'd0);
        checkOutput("tp6_err", 64'(err_cnt),     64'd0);
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, 16'hFFFE);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hFFFF);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000);
        checkOutput("tp6_wrap_seq", 64'(rpt_seq_err), 64'd0);
        checkOutput("tp6_wrap_sum", 64'(rpt_sum),     64'hFFFD);
        checkOutput("tp6_wrap_len", 64'(rpt_len),     64'd3);

        // Randomized traffic against the model.
        for (int p = 0; p < 160; p++) begin
            kind = int'($urandom_range(0, 19));
            case (kind)
                0: applyStimulus(1'b1, 1'b0, 1'($urandom), DATA_W'($urandom));
                1: sendWords(int'($urandom_range(1, 8)), DATA_W'($urandom),
                             1'($urandom), 1'b1, 1'b0, 2);
                2: sendWords(int'($urandom_range(250, 300)), DATA_W'($urandom),
                             1'b1, 1'b1, 1'b1, 1);
                3: applyStimulus(1'b1, 1'b1, 1'b1, DATA_W'($urandom));
                4: if ($urandom_range(0, 3) == 0) resetDut();
                default: sendWords(int'($urandom_range(2, 30)), DATA_W'($urandom),
                                   $urandom_range(0, 3) != 0, 1'b1, 1'b1, 2);
            endcase
            repeat ($urandom_range(0, 3)) idleCycle();
        end
        repeat (5) idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_frame_chk.md
Name: pkt_frame_chk

Overview:
- Packet-stream checker sitting directly downstream of the packet FIFO (fifo_p); consumes its dout_vld/dout_sop/dout_eop/dout stream.
- Validates sop/eop framing, measures packet length and 16-bit data sum, and emits a one-cycle per-packet report.
- Keeps saturating good-packet and error counters for status readout.
- Pure sink with no backpressure: every valid word is consumed in the cycle it is presented.

Parameters:
DATA_W, 16, data word width
LEN_W, 16, length counter / report width
MAX_LEN, 256, longest legal packet in words; longer packets are flagged
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low; all state sampled and cleared on rising clk edge while rst_n=0
din_vld  in  1  word valid
din_sop  in  1  first word of packet (qualified by din_vld)
din_eop  in  1  last word of packet (qualified by din_vld)
din  in  DATA_W  data word
rpt_vld  out  1  one-cycle pulse: packet report valid
rpt_len  out  LEN_W  packet length in words
rpt_sum  out  DATA_W  sum of packet words mod 2^DATA_W
rpt_long  out  1  packet length > MAX_LEN
rpt_seq_err  out  1  sequence error (CONTIG_CHK_EN only, else 0)
err_noeop  out  1  pulse: sop seen inside open packet
err_nosop  out  1  pulse: valid word outside packet without sop
pkt_cnt  out  CNT_W  completed packets, saturating
err_cnt  out  CNT_W  error events, saturating

Behaviour:
- Reset values: all outputs 0; state IDLE; length counter and running sum cleared.
- sop/eop are ignored when din_vld=0. din_vld=0 holds all state.
- FSM, IDLE state:
  - vld&sop&eop: single-word packet completes; stay in IDLE.
  - vld&sop&!eop: go to BODY; len=1, sum=din.
  - vld&!sop: err_nosop pulses next cycle; word discarded (its eop ignored); stay in IDLE.
- FSM, BODY state:
  - vld&!sop&!eop: len+1 (saturating at 2^LEN_W-1); sum+=din.
  - vld&!sop&eop: packet completes; go to IDLE.
  - vld&sop: err_noeop pulses next cycle; open packet is abandoned with no report; the word starts a new packet exactly as in IDLE (a single-word packet if eop is also set).
- Packet completion:
  - Registered outputs change 1 cycle after the eop edge: rpt_vld=1 for exactly one cycle, rpt_len=final len, rpt_sum=final sum.
  - rpt_long = (final len > MAX_LEN), computed on the saturated value.
  - rpt_len/rpt_sum/rpt_long/rpt_seq_err hold until the next report.
- Sum wraps modulo 2^DATA_W; no carry is kept.
- Counters:
  - pkt_cnt increments on every report, including flagged ones.
  - err_cnt increments by the number of error events in a cycle: err_noeop, err_nosop, a report with rpt_long, a report with rpt_seq_err. Two events in one cycle (err_noeop plus a flagged single-word packet) add 2.
  - Both counters saturate at 2^CNT_W-1.
- Back-to-back packets (eop then sop on the next cycle) require zero idle cycles; reports may be one cycle apart.
- Reset mid-packet: partial packet is discarded, no report, counters cleared.

Optional Feature:
- Macro PKT_CONTIG_CHK_EN.
- Defined:
  - Within a packet, each word after the first must equal previous word + 1 mod 2^DATA_W.
  - Any mismatch latches a per-packet flag, reported as rpt_seq_err=1 with the report; the packet counts once in err_cnt however many mismatches occurred.
  - Flag is cleared at each sop.
- Undefined: no previous-word register; rpt_seq_err is tied to 0.

Test Plan:
- 200 words 0..199, sop on first, eop on last -> 1 cycle later rpt_vld pulse, rpt_len=200, rpt_sum=0x4DBC, rpt_long=0, pkt_cnt=1, err_cnt=0.
- 30 idle cycles, then 150 words 200..349 -> rpt_len=150, rpt_sum=0xA0D7, pkt_cnt=2; then a single-word packet (sop&eop, din=5) -> rpt_len=1, rpt_sum=5.
- 300-word packet with MAX_LEN=256 -> rpt_len=300, rpt_long=1, err_cnt+1.
- sop, 10 words, then new sop without eop, 4 words ending in eop -> err_noeop pulse, single report rpt_len=4, err_cnt=1; stray vld word in IDLE without sop -> err_nosop, err_cnt=2, no report.
- rst_n=0 for 1 cycle in the middle of a 50-word packet -> all outputs 0, no report; rest of the words produce err_nosop until the next sop.
- PKT_CONTIG_CHK_EN: packet 0,1,2,7,8 -> rpt_seq_err=1, err_cnt+1; packet 0xFFFE,0xFFFF,0x0000 -> rpt_seq_err=0, rpt_sum=0xFFFD.
